vga_plot_sink: RTL and testbench

- Receiving end of the pixel-plot interface driven by `fillscreen` and later drawing blocks (`vga_x`/`vga_y`/`vga_colour`/`vga_plot`).
- Captures every plotted pixel into an on-chip 160x120x3 frame buffer.
- On request, streams the stored frame back out in column-major order (x outer, y inner) over a valid/ready channel.
- Used as the simulation/readback stand-in for the VGA adapter, so benches can check whole frames pixel by pixel.

---
 rtl/vga_plot_sink_if.sv | 36 +++
 rtl/vga_plot_sink.sv | 122 ++++++++++++
 tb/tb_vga_plot_sink.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vga_plot_sink_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// vga_plot_sink_if: pixel-plot bus plus frame-readback stream.
// Rev 1.0
// ============================================================================
interface vga_plot_sink_if;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        sink_ready;
  logic        scan_start;
  logic        scan_busy;
  logic        scan_done;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [2:0]  px_colour;
  logic [15:0] plot_count;
  logic [15:0] drop_count;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, scan_start, px_ready,
    input  sink_ready, scan_busy, scan_done, px_valid, px_x, px_y, px_colour,
           plot_count, drop_count
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, scan_start, px_ready,
    output sink_ready, scan_busy, scan_done, px_valid, px_x, px_y, px_colour,
           plot_count, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_plot_sink.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// vga_plot_sink: captures plotted pixels into a frame buffer and streams the
// frame back column-major over valid/ready.   Rev 1.0
// ============================================================================
module vga_plot_sink #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic           clk,
  input  logic           rst,
  vga_plot_sink_if.slave bus
);
  localparam int unsigned     c_depth  = WIDTH * HEIGHT;
  localparam int unsigned     c_aw     = $clog2(c_depth);
  localparam logic [c_aw-1:0] c_last   = c_aw'(c_depth - 1);
  localparam logic [c_aw-1:0] c_h      = c_aw'(HEIGHT);
  localparam logic [7:0]      c_x_last = 8'(WIDTH - 1);
  localparam logic [6:0]      c_y_last = 7'(HEIGHT - 1);
  localparam logic [15:0]     c_sat    = 16'hFFFF;

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_IDLE     = 3'd1,
    S_SCAN_RD  = 3'd2,
    S_SCAN_OUT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_mem [0:c_depth-1];
  logic [c_aw-1:0] r_clr;
  logic [7:0]      r_x;
  logic [6:0]      r_y;
  logic [2:0]      r_rd;
  logic [15:0]     r_plot_cnt, r_drop_cnt;

  logic            w_in_range, w_plot_ok, w_plot_drop, w_we, w_last_px, w_hs;
  logic [c_aw-1:0] w_paddr, w_raddr, w_waddr;
  logic [2:0]      w_wdata;

  assign w_in_range  = (bus.vga_x <= c_x_last) && (bus.vga_y <= c_y_last);
  assign w_plot_ok   = bus.vga_plot && (r_state != S_CLEAR) && w_in_range;
  assign w_plot_drop = bus.vga_plot && ((r_state == S_CLEAR) || !w_in_range);
  assign w_paddr     = c_aw'(bus.vga_x) * c_h + c_aw'(bus.vga_y);
  assign w_raddr     = c_aw'(r_x) * c_h + c_aw'(r_y);
  assign w_last_px   = (r_x == c_x_last) && (r_y == c_y_last);
  assign w_hs        = (r_state == S_SCAN_OUT) && bus.px_ready;

  // The clear sweep owns the write port; plots are dropped meanwhile.
  assign w_we    = (r_state == S_CLEAR) || w_plot_ok;
  assign w_waddr = (r_state == S_CLEAR) ? r_clr : w_paddr;
  assign w_wdata = (r_state == S_CLEAR) ? 3'd0 : bus.vga_colour;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:    if (r_clr == c_last) w_next = S_IDLE;
      S_IDLE:     if (bus.scan_start) w_next = S_SCAN_RD;
      S_SCAN_RD:  w_next = S_SCAN_OUT;
      S_SCAN_OUT: if (bus.px_ready) w_next = w_last_px ? S_DONE : S_SCAN_RD;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_rd       <= '0;
      r_plot_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_state == S_CLEAR) r_clr <= r_clr + 1'b1;

      if ((r_state == S_IDLE) && bus.scan_start) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_hs && !w_last_px) begin
        if (r_y == c_y_last) begin
          r_y <= '0;
          r_x <= r_x + 8'd1;
        end else begin
          r_y <= r_y + 7'd1;
        end
      end

      // Read only in SCAN_RD so the presented colour holds while stalled;
      // a same-cycle plot to the read address is forwarded.
      if (r_state == S_SCAN_RD) begin
        if (w_plot_ok && (w_paddr == w_raddr)) r_rd <= bus.vga_colour;
        else                                   r_rd <= r_mem[w_raddr];
      end

      if (w_plot_ok && (r_plot_cnt != c_sat))   r_plot_cnt <= r_plot_cnt + 16'd1;
      if (w_plot_drop && (r_drop_cnt != c_sat)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.sink_ready = (r_state != S_CLEAR);
  assign bus.scan_busy  = (r_state == S_SCAN_RD) || (r_state == S_SCAN_OUT);
  assign bus.scan_done  = (r_state == S_DONE);
  assign bus.px_valid   = (r_state == S_SCAN_OUT);
  assign bus.px_x       = r_x;
  assign bus.px_y       = r_y;
  assign bus.px_colour  = r_rd;
  assign bus.plot_count = r_plot_cnt;
  assign bus.drop_count = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_vga_plot_sink.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_vga_plot_sink: directed checks of clear, plot capture, readback and reset.
// Rev 1.0
// ============================================================================
module tb_vga_plot_sink;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_plot_sink_if bus ();

  vga_plot_sink #(.WIDTH(160), .HEIGHT(120)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         total = 0;
  int         bad   = 0;
  logic [2:0] model [0:159][0:119];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.vga_x      = x;
    bus.vga_y      = y;
    bus.vga_colour = c;
    bus.vga_plot   = 1'b1;
    tick();
    bus.vga_plot   = 1'b0;
  endtask

  initial begin
    int          ex, ey, pix, guard, n;
    logic        stalled, bypass_pending, did_hold;
    logic [17:0] held;

    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) model[x][y] = 3'd0;

    bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
    bus.scan_start = 1'b0; bus.px_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_sink_ready", bus.sink_ready, 0);
    check("rst_busy_done_valid", {bus.scan_busy, bus.scan_done, bus.px_valid}, 0);
    check("rst_px", {bus.px_x, bus.px_y, bus.px_colour}, 0);
    check("rst_counts", {bus.plot_count, bus.drop_count}, 0);
    rst = 1'b0;

    // Clear sweep, with one plot dropped at cycle 100
    for (int i = 1; i <= 19200; i++) begin
      if (i == 100) begin
        bus.vga_x = 8'd0; bus.vga_y = 7'd0; bus.vga_colour = 3'd7; bus.vga_plot = 1'b1;
      end
      tick();
      bus.vga_plot = 1'b0;
      if (i == 19199) check("ready_low_at_19199", bus.sink_ready, 0);
    end
    check("ready_high_at_19200", bus.sink_ready, 1);
    check("drop_after_clear_plot", bus.drop_count, 1);
    check("plot_after_clear", bus.plot_count, 0);

    // Directed plots including overwrite and out-of-range
    plot(8'd1,   7'd0,   3'd3); model[1][0]     = 3'd3;
    plot(8'd0,   7'd1,   3'd6); model[0][1]     = 3'd6;
    plot(8'd159, 7'd119, 3'd7); model[159][119] = 3'd7;
    plot(8'd2,   7'd5,   3'd1);
    plot(8'd2,   7'd5,   3'd4); model[2][5]     = 3'd4;
    plot(8'd160, 7'd0,   3'd5);
    plot(8'd0,   7'd120, 3'd5);
    check("plot_count_5", bus.plot_count, 5);
    check("drop_count_3", bus.drop_count, 3);
    check("idle_not_busy", bus.scan_busy, 0);

    // Full scan with stalls, one held-collision and one read bypass
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    check("busy_after_start", bus.scan_busy, 1);
    check("valid_low_in_rd", bus.px_valid, 0);

    ex = 0; ey = 0; pix = 0; guard = 0;
    stalled = 1'b0; bypass_pending = 1'b0; did_hold = 1'b0; held = '0;
    while (guard < 60000) begin
      if (bus.scan_done) break;
      bus.vga_plot = 1'b0;
      if (bypass_pending) begin
        bus.vga_x = 8'd5; bus.vga_y = 7'd10; bus.vga_colour = 3'd2; bus.vga_plot = 1'b1;
        bypass_pending = 1'b0;
      end
      if (bus.px_valid) begin
        if (stalled) check("held_while_stalled", {bus.px_x, bus.px_y, bus.px_colour}, held);
        if (ex == 7 && ey == 7 && !did_hold) begin
          did_hold = 1'b1;
          bus.px_ready = 1'b0;
          bus.vga_x = 8'd7; bus.vga_y = 7'd7; bus.vga_colour = 3'd3; bus.vga_plot = 1'b1;
        end else begin
          bus.px_ready = ($urandom_range(0, 15) != 0);
        end
        if (bus.px_ready) begin
          check("pixel", {bus.px_x, bus.px_y, bus.px_colour}, {ex[7:0], ey[6:0], model[ex][ey]});
          if (ex == 5 && ey == 9) begin
            bypass_pending = 1'b1;
            model[5][10]   = 3'd2;
          end
          pix++;
          if (ey == 119) begin ey = 0; ex++; end
          else ey++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {bus.px_x, bus.px_y, bus.px_colour};
        end
      end
      tick();
      guard++;
    end
    bus.vga_plot = 1'b0;
    check("scan_done_seen", bus.scan_done, 1);
    check("pixels_scanned", pix, 19200);
    check("done_state_outputs", {bus.scan_busy, bus.px_valid}, 0);
    check("last_px_position", {bus.px_x, bus.px_y}, {8'd159, 7'd119});
    tick();
    check("done_single_pulse", bus.scan_done, 0);
    check("plot_count_7", bus.plot_count, 7);
    check("drop_count_still_3", bus.drop_count, 3);

    // Second scan, reset at pixel (10,5)
    bus.px_ready   = 1'b1;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    guard = 0;
    while (!(bus.px_valid && bus.px_x == 8'd10 && bus.px_y == 7'd5) && guard < 5000) begin
      tick();
      guard++;
    end
    check("reached_10_5", {bus.px_valid, bus.px_x, bus.px_y}, {1'b1, 8'd10, 7'd5});
    rst = 1'b1;
    tick();
    check("midscan_rst_valid_busy", {bus.px_valid, bus.scan_busy, bus.scan_done}, 0);
    check("midscan_rst_counts", {bus.plot_count, bus.drop_count}, 0);
    check("midscan_rst_sink_ready", bus.sink_ready, 0);
    check("midscan_rst_px", {bus.px_x, bus.px_y, bus.px_colour}, 0);
    rst = 1'b0;
    n = 0;
    while (!bus.sink_ready && n < 20000) begin
      tick();
      n++;
    end
    check("reclear_cycles", n, 19200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
